// File: rtl/pic_priority_inta_ctrl.sv
// Priority resolver, ISR keeper and 8086 two-pulse INTA sequencer for an
// 8259-style interrupt controller. The masked request vector comes from the
// request register. This block returns the serviced level to that stage as a
// one-hot chosen mask plus a one-cycle clear strobe.
module pic_priority_inta_ctrl #(
  parameter int NUM_IR         = 8,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_IR-1:0] irr_i,
  input  logic [NUM_IR-1:0] imr_i,
  input  logic              inta_n_i,
  input  logic [4:0]        icw2_base_i,
  input  logic              aeoi_i,
  input  logic              rot_aeoi_i,
  input  logic              eoi_cmd_i,
  input  logic              eoi_specific_i,
  input  logic              eoi_rotate_i,
  input  logic [2:0]        eoi_level_i,
  output logic              int_out_o,
  output logic [NUM_IR-1:0] isr_o,
  output logic [NUM_IR-1:0] chosen_o,
  output logic              clr_strobe_o,
  output logic [7:0]        vector_out_o,
  output logic              vector_oe_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } state_e;

  localparam logic [NUM_IR-1:0] ONE_HOT_0  = {{(NUM_IR-1){1'b0}}, 1'b1};
  localparam logic [NUM_IR-1:0] SPUR_MASK  = ONE_HOT_0 << SPURIOUS_LEVEL;

  // Registered state
  state_e            state_q;
  logic              inta_n_q;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [2:0]        lp_q, lp_d;
  logic [NUM_IR-1:0] chosen_q;
  logic              spurious_q;
  logic              clr_strobe_q;
  logic              int_q;
  logic [7:0]        vector_q;
  logic              vector_oe_q;

  // Combinational resolution results
  logic [NUM_IR-1:0] req;
  logic [2:0]        win_lvl;
  logic [2:0]        isr_top;
  logic              win_valid;
  logic              inta_fall;
  logic              inta_rise;
  logic [2:0]        chosen_lvl;
  logic [NUM_IR-1:0] set_mask;
  logic              aeoi_hit;
  logic [NUM_IR-1:0] aeoi_clr;
  logic [2:0]        eoi_lvl;
  logic              eoi_hit;
  logic [NUM_IR-1:0] eoi_clr;

  // Highest-priority set bit of v when lp is the lowest-priority level.
  // Scanning from the lowest rank upward lets the last hit win.
  function automatic logic [2:0] top_level(input logic [NUM_IR-1:0] v,
                                           input logic [2:0] lp);
    logic [2:0] r;
    logic [2:0] idx;
    r = 3'd0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = lp + 3'd1 + 3'(k);
      if (v[idx]) r = idx;
    end
    return r;
  endfunction

  // Rank 0 is the highest priority, rank 7 belongs to lp itself.
  function automatic logic [2:0] rank_of(input logic [2:0] lvl,
                                         input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  // Binary level of a one-hot mask.
  function automatic logic [2:0] encode(input logic [NUM_IR-1:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < NUM_IR; k++) begin
      if (oh[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Priority resolution against the in-service register, plus INTA edge detect.
  always_comb begin
    req        = irr_i & ~imr_i;
    win_lvl    = top_level(req, lp_q);
    isr_top    = top_level(isr_q, lp_q);
    win_valid  = (|req) &&
                 ((isr_q == '0) || (rank_of(win_lvl, lp_q) < rank_of(isr_top, lp_q)));
    inta_fall  = inta_n_q & ~inta_n_i;
    inta_rise  = ~inta_n_q & inta_n_i;
    chosen_lvl = encode(chosen_q);
  end

  // Next ISR and priority pointer: set on acknowledge, clear on EOI / AEOI.
  // The EOI looks at the ISR as it was before this edge's set.
  always_comb begin
    set_mask = '0;
    if (state_q == IDLE && inta_fall && win_valid) set_mask = ONE_HOT_0 << win_lvl;

    aeoi_hit = (state_q == ACK2) && inta_rise && aeoi_i && !spurious_q;
    aeoi_clr = aeoi_hit ? chosen_q : '0;

    eoi_lvl  = eoi_specific_i ? eoi_level_i : isr_top;
    eoi_hit  = eoi_cmd_i && (eoi_specific_i ? isr_q[eoi_level_i] : (isr_q != '0));
    eoi_clr  = eoi_hit ? (ONE_HOT_0 << eoi_lvl) : '0;

    isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | set_mask;

    lp_d = lp_q;
    if (eoi_hit && eoi_rotate_i) begin
      lp_d = eoi_lvl;
    end else if (aeoi_hit && rot_aeoi_i) begin
      lp_d = chosen_lvl;
    end
  end

  // INTA handshake FSM with all CPU-facing and IRR-facing outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      inta_n_q     <= 1'b1;
      isr_q        <= '0;
      lp_q         <= 3'd7;
      chosen_q     <= '0;
      spurious_q   <= 1'b0;
      clr_strobe_q <= 1'b0;
      int_q        <= 1'b0;
      vector_q     <= 8'h00;
      vector_oe_q  <= 1'b0;
    end else begin
      inta_n_q     <= inta_n_i;
      isr_q        <= isr_d;
      lp_q         <= lp_d;
      clr_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inta_fall) begin
            state_q    <= ACK1;
            int_q      <= 1'b0;
            spurious_q <= !win_valid;
            if (win_valid) begin
              chosen_q     <= ONE_HOT_0 << win_lvl;
              clr_strobe_q <= 1'b1;
            end else begin
              chosen_q     <= SPUR_MASK;
            end
          end else begin
            int_q <= win_valid;
          end
        end
        ACK1: begin
          int_q <= 1'b0;
          if (inta_rise) state_q <= WAIT2;
        end
        WAIT2: begin
          int_q <= 1'b0;
          if (inta_fall) begin
            state_q     <= ACK2;
            vector_q    <= {icw2_base_i, chosen_lvl};
            vector_oe_q <= 1'b1;
          end
        end
        ACK2: begin
          int_q <= 1'b0;
          if (inta_rise) begin
            state_q     <= IDLE;
            vector_oe_q <= 1'b0;
            chosen_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

  assign int_out_o    = int_q;
  assign isr_o        = isr_q;
  assign chosen_o     = chosen_q;
  assign clr_strobe_o = clr_strobe_q;
  assign vector_out_o = vector_q;
  assign vector_oe_o  = vector_oe_q;

endmodule

// File: tb/tb_pic_priority_inta_ctrl.sv
// Directed bench for pic_priority_inta_ctrl: a table of single-handshake
// scenarios from reset, then hand-written nesting, AEOI, EOI and reset cases.
module tb_pic_priority_inta_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic [4:0] base;
  logic       aeoi;
  logic       rot_aeoi;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] chosen;
  logic       clr_strobe;
  logic [7:0] vector_out;
  logic       vector_oe;

  int checks = 0;
  int errors = 0;

  pic_priority_inta_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .irr_i          (irr),
    .imr_i          (imr),
    .inta_n_i       (inta_n),
    .icw2_base_i    (base),
    .aeoi_i         (aeoi),
    .rot_aeoi_i     (rot_aeoi),
    .eoi_cmd_i      (eoi_cmd),
    .eoi_specific_i (eoi_specific),
    .eoi_rotate_i   (eoi_rotate),
    .eoi_level_i    (eoi_level),
    .int_out_o      (int_out),
    .isr_o          (isr),
    .chosen_o       (chosen),
    .clr_strobe_o   (clr_strobe),
    .vector_out_o   (vector_out),
    .vector_oe_o    (vector_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] base;
    logic       exp_int;
    logic [7:0] exp_chosen;
    logic       exp_clr;
    logic [7:0] exp_vec;
    logic [7:0] exp_isr;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irr = 8'h00; imr = 8'h00; inta_n = 1'b1; base = 5'h08;
    aeoi = 1'b0; rot_aeoi = 1'b0;
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full two-pulse acknowledge; optionally withdraws irr after the first fall.
  task automatic handshake(input logic withdraw,
                           output logic [7:0] ch1, output logic clr1, output logic int1,
                           output logic [7:0] ch2, output logic [7:0] vec, output logic oe,
                           output logic [7:0] ch_after, output logic oe_after,
                           output int clr_cnt);
    inta_n = 1'b0; tick();
    ch1 = chosen; clr1 = clr_strobe; int1 = int_out; clr_cnt = int'(clr_strobe);
    if (withdraw) irr = 8'h00;
    tick();                 clr_cnt += int'(clr_strobe);
    inta_n = 1'b1; tick();  clr_cnt += int'(clr_strobe);
    inta_n = 1'b0; tick();  clr_cnt += int'(clr_strobe);
    ch2 = chosen; vec = vector_out; oe = vector_oe;
    inta_n = 1'b1; tick();
    ch_after = chosen; oe_after = vector_oe;
  endtask

  task automatic eoi(input logic specific, input logic rotate, input logic [2:0] lvl);
    eoi_cmd = 1'b1; eoi_specific = specific; eoi_rotate = rotate; eoi_level = lvl;
    tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
  endtask

  initial begin
    logic [7:0] ch1, ch2, vec, ch_after;
    logic clr1, int1, oe, oe_after;
    int clr_cnt;

    //            irr    imr    base   int   chosen clr  vec    isr
    tbl[0] = '{8'h0A, 8'h00, 5'h08, 1'b1, 8'h02, 1'b1, 8'h41, 8'h02};
    tbl[1] = '{8'h0A, 8'h02, 5'h08, 1'b1, 8'h08, 1'b1, 8'h43, 8'h08};
    tbl[2] = '{8'h80, 8'h00, 5'h08, 1'b1, 8'h80, 1'b1, 8'h47, 8'h80};
    tbl[3] = '{8'hFF, 8'hFE, 5'h08, 1'b1, 8'h01, 1'b1, 8'h40, 8'h01};
    tbl[4] = '{8'h00, 8'h00, 5'h08, 1'b0, 8'h80, 1'b0, 8'h47, 8'h00};
    tbl[5] = '{8'h30, 8'h30, 5'h08, 1'b0, 8'h80, 1'b0, 8'h47, 8'h00};
    tbl[6] = '{8'hF0, 8'h10, 5'h1F, 1'b1, 8'h20, 1'b1, 8'hFD, 8'h20};

    // Reset state
    do_reset();
    chk("rst_isr", 32'(isr), 32'h00);
    chk("rst_int", 32'(int_out), 32'h0);
    chk("rst_chosen", 32'(chosen), 32'h00);
    chk("rst_clr", 32'(clr_strobe), 32'h0);
    chk("rst_vec", 32'(vector_out), 32'h00);
    chk("rst_oe", 32'(vector_oe), 32'h0);
    chk("rst_lp", 32'(dut.lp_q), 32'd7);

    // Table-driven single handshakes, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      do_reset();
      irr = tbl[i].irr; imr = tbl[i].imr; base = tbl[i].base;
      if (i == 0) chk("t0_int_before", 32'(int_out), 32'h0);
      tick();
      chk($sformatf("t%0d_int", i), 32'(int_out), 32'(tbl[i].exp_int));
      handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
      chk($sformatf("t%0d_chosen", i), 32'(ch1), 32'(tbl[i].exp_chosen));
      chk($sformatf("t%0d_clr_ack1", i), 32'(clr1), 32'(tbl[i].exp_clr));
      chk($sformatf("t%0d_clr_count", i), 32'(clr_cnt), 32'(tbl[i].exp_clr));
      chk($sformatf("t%0d_int_drop", i), 32'(int1), 32'h0);
      chk($sformatf("t%0d_vec", i), 32'(vec), 32'(tbl[i].exp_vec));
      chk($sformatf("t%0d_oe", i), 32'(oe), 32'h1);
      chk($sformatf("t%0d_isr", i), 32'(isr), 32'(tbl[i].exp_isr));
      chk($sformatf("t%0d_chosen_after", i), 32'(ch_after), 32'h00);
      chk($sformatf("t%0d_oe_after", i), 32'(oe_after), 32'h0);
    end

    // Fully nested: IR0 over in-service IR1, IR1 blocked by in-service IR0
    do_reset();
    irr = 8'h02; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("nest_isr02", 32'(isr), 32'h02);
    irr = 8'h01; tick();
    chk("nest_int_ir0", 32'(int_out), 32'h1);
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("nest_isr03", 32'(isr), 32'h03);
    eoi(1'b1, 1'b0, 3'd1);
    chk("nest_isr01", 32'(isr), 32'h01);
    irr = 8'h02; tick(); tick();
    chk("nest_int_blocked", 32'(int_out), 32'h0);

    // Request withdrawn after the first INTA: chosen must hold
    do_reset();
    irr = 8'h10; tick();
    handshake(1'b1, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("wd_chosen_ack1", 32'(ch1), 32'h10);
    chk("wd_chosen_ack2", 32'(ch2), 32'h10);
    chk("wd_vec", 32'(vec), 32'h44);
    chk("wd_isr", 32'(isr), 32'h10);

    // AEOI with rotation
    do_reset();
    aeoi = 1'b1; rot_aeoi = 1'b1;
    irr = 8'h08; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("aeoi_chosen", 32'(ch1), 32'h08);
    chk("aeoi_isr", 32'(isr), 32'h00);
    chk("aeoi_lp", 32'(dut.lp_q), 32'd3);
    irr = 8'h18; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("aeoi_rot_winner", 32'(ch1), 32'h10);
    chk("aeoi_rot_vec", 32'(vec), 32'h44);
    aeoi = 1'b0; rot_aeoi = 1'b0;

    // ISR set and non-specific EOI on the same edge
    do_reset();
    irr = 8'h04; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    irr = 8'h01; tick();
    eoi_cmd = 1'b1; inta_n = 1'b0; tick();
    eoi_cmd = 1'b0;
    chk("same_edge_isr", 32'(isr), 32'h01);
    inta_n = 1'b1; tick(); inta_n = 1'b0; tick(); inta_n = 1'b1; tick();

    // Non-specific and specific rotating EOI
    do_reset();
    irr = 8'h04; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    irr = 8'h01; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    irr = 8'h00;
    chk("eoi_isr05", 32'(isr), 32'h05);
    eoi(1'b0, 1'b0, 3'd0);
    chk("eoi_ns_isr", 32'(isr), 32'h04);
    eoi(1'b1, 1'b1, 3'd2);
    chk("eoi_sp_isr", 32'(isr), 32'h00);
    chk("eoi_sp_lp", 32'(dut.lp_q), 32'd2);
    eoi(1'b0, 1'b1, 3'd0);
    chk("eoi_empty_lp", 32'(dut.lp_q), 32'd2);
    irr = 8'h09; tick();
    handshake(1'b0, ch1, clr1, int1, ch2, vec, oe, ch_after, oe_after, clr_cnt);
    chk("eoi_rot_winner", 32'(ch1), 32'h08);
    chk("eoi_rot_isr", 32'(isr), 32'h08);

    // Asynchronous reset in the middle of ACK2
    irr = 8'h00;
    inta_n = 1'b0; tick(); inta_n = 1'b1; tick(); inta_n = 1'b0; tick();
    chk("mid_oe", 32'(vector_oe), 32'h1);
    rst_n = 1'b0; #1;
    chk("mid_rst_isr", 32'(isr), 32'h00);
    chk("mid_rst_chosen", 32'(chosen), 32'h00);
    chk("mid_rst_oe", 32'(vector_oe), 32'h0);
    chk("mid_rst_vec", 32'(vector_out), 32'h00);
    chk("mid_rst_int", 32'(int_out), 32'h0);
    chk("mid_rst_clr", 32'(clr_strobe), 32'h0);
    chk("mid_rst_lp", 32'(dut.lp_q), 32'd7);
    inta_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
